ddr_arbiter: RTL and testbench

Schedules access to the single-port DDR command core for two requesters: the VGA scan-out fetch (read-only) and the drawing engine (write-only). It also generates periodic auto-refresh requests. It sits between the requester logic and the DDR command/datapath core. It issues one command at a time, routes read data back to the video port, and guarantees refresh service.

---
 rtl/ddr_pkg.sv | 22 ++
 rtl/ddr_refresh_timer.sv | 54 +++++
 rtl/ddr_arbiter.sv | 143 ++++++++++++++
 tb/tb_ddr_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types for the DDR arbiter slice: command opcodes, arbiter states,
// default address width and the refresh-pending saturation level.
package ddr_pkg;

  typedef enum logic [1:0] {
    CMD_READ    = 2'b00,
    CMD_WRITE   = 2'b01,
    CMD_REFRESH = 2'b10
  } cmd_op_e;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    ISSUE     = 2'd2,
    BUSY      = 2'd3
  } arb_state_e;

  localparam int DDR_ADDR_W   = 24;
  localparam int REF_PEND_MAX = 8;
  localparam int REF_PEND_W   = $clog2(REF_PEND_MAX + 1);

endpackage

// File: rtl/ddr_refresh_timer.sv
// Auto-refresh interval counter with a saturating count of owed refreshes
// and a sticky flag for ticks lost because the count was already full.
module ddr_refresh_timer
  import ddr_pkg::*;
#(
  parameter int INTERVAL = 1000
) (
  input  logic clk133_p,
  input  logic rst,
  input  logic run_i,
  input  logic acc_i,
  output logic pending_nz_o,
  output logic overflow_o
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [TW-1:0]         tmr_q, tmr_d;
  logic [REF_PEND_W-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  wrap;

  assign wrap = run_i && (tmr_q == TW'(INTERVAL - 1));

  always_comb begin
    tmr_d  = '0;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (run_i && !wrap) tmr_d = tmr_q + 1'b1;
    // a tick and an accepted refresh in the same cycle cancel out
    if (wrap && !acc_i) begin
      if (pend_q == REF_PEND_W'(REF_PEND_MAX)) ovf_d = 1'b1;
      else                                    pend_d = pend_q + 1'b1;
    end else if (acc_i && !wrap && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      tmr_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pending_nz_o = (pend_q != '0);
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/ddr_arbiter.sv
// Single-command DDR arbiter: refresh > video read > draw write.
// Define DDR_ARB_STARVE_GUARD_EN to let draw win once after STARVE_LIMIT video grants.
module ddr_arbiter
  import ddr_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 1000,
  parameter int STARVE_LIMIT     = 8,
  parameter int ADDR_W           = DDR_ADDR_W
) (
  input  logic              clk133_p,
  input  logic              rst,
  input  logic              init_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [31:0]       vid_data,
  output logic              vid_valid,
  input  logic              drw_req,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [31:0]       drw_data,
  output logic              drw_ack,
  output logic              cmd_valid,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [31:0]       cmd_wdata,
  input  logic              cmd_ready,
  input  logic              cmd_done,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic              refresh_overflow
);

  arb_state_e        state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, vdata_q;
  logic              vack_q, vack_d, dack_q, dack_d;
  logic              rd_out_q, rd_out_d, vvld_q;
  logic              ref_pend, ref_acc, vid_gnt, drw_gnt, starve_hit;

  ddr_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_refresh (
    .clk133_p     (clk133_p),
    .rst          (rst),
    .run_i        (state_q != WAIT_INIT),
    .acc_i        (ref_acc),
    .pending_nz_o (ref_pend),
    .overflow_o   (refresh_overflow)
  );

`ifdef DDR_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit = drw_req && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (vid_gnt && drw_req && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
    if (drw_gnt || !drw_req) starve_d = '0;
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  // strict priority: draw is never promoted over video
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  assign vid_gnt = (state_q == IDLE) && !ref_pend && vid_req && !starve_hit;
  assign drw_gnt = (state_q == IDLE) && !ref_pend && drw_req && !vid_gnt;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    vack_d   = 1'b0;
    dack_d   = 1'b0;
    ref_acc  = 1'b0;
    rd_out_d = rd_out_q;
    case (state_q)
      WAIT_INIT: if (init_done) state_d = IDLE;
      IDLE: begin
        if (ref_pend) begin
          op_d = CMD_REFRESH; addr_d = '0; wdata_d = '0; state_d = ISSUE;
        end else if (vid_gnt) begin
          op_d = CMD_READ; addr_d = vid_addr; wdata_d = '0; state_d = ISSUE;
        end else if (drw_gnt) begin
          op_d = CMD_WRITE; addr_d = drw_addr; wdata_d = drw_data; state_d = ISSUE;
        end
      end
      ISSUE: if (cmd_ready) begin
        // acks come from the latched op, even if the requester already let go
        state_d  = BUSY;
        vack_d   = (op_q == CMD_READ);
        dack_d   = (op_q == CMD_WRITE);
        ref_acc  = (op_q == CMD_REFRESH);
        rd_out_d = (op_q == CMD_READ);
      end
      BUSY: if (cmd_done) begin
        state_d  = IDLE;
        rd_out_d = 1'b0;
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk133_p or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_INIT;
      op_q     <= CMD_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      vack_q   <= 1'b0;
      dack_q   <= 1'b0;
      rd_out_q <= 1'b0;
      vvld_q   <= 1'b0;
      vdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      vack_q   <= vack_d;
      dack_q   <= dack_d;
      rd_out_q <= rd_out_d;
      vvld_q   <= rd_valid && rd_out_q;
      if (rd_valid && rd_out_q) vdata_q <= rd_data;
    end
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_op    = op_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;
  assign vid_ack   = vack_q;
  assign drw_ack   = dack_q;
  assign vid_valid = vvld_q;
  assign vid_data  = vdata_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Directed-plus-random bench for ddr_arbiter against a transaction-level
// model of the arbitration, refresh and read-return rules.
module tb_ddr_arbiter;
  import ddr_pkg::*;

  localparam int RI = 20;
  localparam int SL = 8;
  localparam int AW = 24;
`ifdef DDR_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk133_p = 1'b0;
  logic          rst, init_done, vid_req, drw_req, cmd_ready, cmd_done, rd_valid;
  logic [AW-1:0] vid_addr, drw_addr, cmd_addr;
  logic [31:0]   drw_data, vid_data, cmd_wdata, rd_data;
  logic          vid_ack, vid_valid, drw_ack, cmd_valid, refresh_overflow;
  logic [1:0]    cmd_op;

  int checks = 0;
  int errors = 0;

  always #5 clk133_p = ~clk133_p;

  ddr_arbiter #(.REFRESH_INTERVAL(RI), .STARVE_LIMIT(SL), .ADDR_W(AW)) dut (
    .clk133_p(clk133_p), .rst(rst), .init_done(init_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_data(vid_data), .vid_valid(vid_valid),
    .drw_req(drw_req), .drw_addr(drw_addr), .drw_data(drw_data), .drw_ack(drw_ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .rd_valid(rd_valid), .rd_data(rd_data),
    .refresh_overflow(refresh_overflow)
  );

  // reference model
  bit   m_init, m_free, m_issue, m_busy, m_rdout, m_ovf;
  int   m_pend, m_tc, m_sc;
  logic [1:0] m_op;
  int   n_rd, n_wr, cur_run, max_run;
  // core responder / requester control
  bit   c_busy, c_rd, hold_ready, rand_ready, stray_en, fixed_rd, seen_vv;
  int   c_cnt, lat_min, lat_max, rq_mode, cyc_n, last_vack, last_dack;
  logic [31:0] last_vdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 0; m_free = 0; m_issue = 0; m_busy = 0; m_rdout = 0; m_ovf = 0;
    m_pend = 0; m_tc = 0; m_sc = 0; m_op = 2'b00; c_busy = 0; c_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_cmd_op"}, 32'(cmd_op), 32'd0);
    chk({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
    chk({tag, "_cmd_wdata"}, cmd_wdata, 32'd0);
    chk({tag, "_acks"}, 32'({vid_ack, drw_ack, vid_valid}), 32'd0);
    chk({tag, "_vid_data"}, vid_data, 32'd0);
    chk({tag, "_overflow"}, 32'(refresh_overflow), 32'd0);
  endtask

  // One clock: snapshot pre-edge inputs, advance the model, compare, drive next inputs.
  task automatic cyc();
    logic s_vid, s_drw, s_rdy, s_done, s_rdv, s_init, s_cv;
    logic [1:0] s_op, e_op;
    logic [AW-1:0] s_va, s_da, e_a;
    logic [31:0] s_dd, s_rdd, e_w;
    bit xfer, tick, acc, pre_init, old_rdout, exp_vv;
    s_vid = vid_req; s_drw = drw_req; s_rdy = cmd_ready; s_done = cmd_done;
    s_rdv = rd_valid; s_init = init_done; s_cv = cmd_valid; s_op = cmd_op;
    s_va = vid_addr; s_da = drw_addr; s_dd = drw_data; s_rdd = rd_data;
    @(posedge clk133_p);
    @(negedge clk133_p);
    cyc_n++;
    xfer = 0; acc = 0; pre_init = m_init; old_rdout = m_rdout;
    tick = 0;
    if (pre_init) begin
      m_tc++;
      tick = (m_tc % RI) == 0;
    end
    if (!m_init) begin
      if (s_init) begin m_init = 1; m_free = 1; end
    end else if (m_free) begin
      if (m_pend > 0 || s_vid || s_drw) begin
        m_free = 0; m_issue = 1;
        if (m_pend > 0) begin
          e_op = 2'b10; e_a = '0; e_w = '0;
        end else if (s_vid && !(GUARD && s_drw && m_sc == SL)) begin
          e_op = 2'b00; e_a = s_va; e_w = '0;
          if (s_drw && m_sc < SL) m_sc++;
          n_rd++; cur_run++;
          if (cur_run > max_run) max_run = cur_run;
        end else begin
          e_op = 2'b01; e_a = s_da; e_w = s_dd;
          m_sc = 0; n_wr++; cur_run = 0;
        end
        m_op = e_op;
        chk("grant_op", 32'(cmd_op), 32'(e_op));
        chk("grant_addr", 32'(cmd_addr), 32'(e_a));
        chk("grant_wdata", cmd_wdata, e_w);
      end
    end else if (m_issue) begin
      if (s_rdy) begin
        m_issue = 0; m_busy = 1; xfer = 1;
        acc = (m_op == 2'b10);
        if (m_op == 2'b00) m_rdout = 1;
      end
    end else if (m_busy) begin
      if (s_done) begin m_busy = 0; m_free = 1; m_rdout = 0; end
    end
    if (!s_drw) m_sc = 0;
    if (tick && !acc) begin
      if (m_pend == REF_PEND_MAX) m_ovf = 1; else m_pend++;
    end else if (acc && !tick) begin
      m_pend--;
    end
    exp_vv = s_rdv && old_rdout;
    chk("cmd_valid", 32'(cmd_valid), 32'(m_issue));
    chk("vid_ack", 32'(vid_ack), 32'(xfer && m_op == 2'b00));
    chk("drw_ack", 32'(drw_ack), 32'(xfer && m_op == 2'b01));
    chk("vid_valid", 32'(vid_valid), 32'(exp_vv));
    if (exp_vv) chk("vid_data", vid_data, s_rdd);
    chk("refresh_overflow", 32'(refresh_overflow), 32'(m_ovf));
    if (vid_valid) begin seen_vv = 1; last_vdata = vid_data; end
    if (vid_ack) last_vack = cyc_n;
    if (drw_ack) last_dack = cyc_n;
    // core responder
    cmd_done = 0; rd_valid = 0;
    if (s_cv && s_rdy) begin
      c_busy = 1; c_rd = (s_op == 2'b00); c_cnt = $urandom_range(lat_max, lat_min);
    end
    if (c_busy) begin
      c_cnt--;
      if (c_cnt == 0) begin cmd_done = 1; c_busy = 0; end
      else if (c_cnt == 1 && c_rd) begin
        rd_valid = 1; rd_data = fixed_rd ? 32'h5555AAAA : $urandom;
      end
    end else if (stray_en && $urandom_range(7, 0) == 0) begin
      rd_valid = 1; rd_data = $urandom;
    end
    cmd_ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(3, 0) != 0) : 1'b1);
    // requesters
    if (vid_ack) begin vid_req = (rq_mode == 2); vid_addr = AW'($urandom); end
    if (drw_ack) begin drw_req = (rq_mode == 2); drw_addr = AW'($urandom); drw_data = $urandom; end
    if (rq_mode == 1) begin
      if (!vid_req && !vid_ack && $urandom_range(3, 0) == 0) vid_req = 1;
      if (!drw_req && !drw_ack && $urandom_range(3, 0) == 0) drw_req = 1;
    end
  endtask

  initial begin
    bit got;
    rst = 1; init_done = 0; vid_req = 0; drw_req = 0; vid_addr = '0; drw_addr = '0;
    drw_data = '0; cmd_ready = 0; cmd_done = 0; rd_valid = 0; rd_data = '0;
    hold_ready = 0; rand_ready = 0; stray_en = 0; fixed_rd = 0; seen_vv = 0;
    lat_min = 4; lat_max = 4; rq_mode = 0; cyc_n = 0; last_vack = 0; last_dack = 0;
    n_rd = 0; n_wr = 0; cur_run = 0; max_run = 0; last_vdata = '0;
    model_reset();
    repeat (3) @(negedge clk133_p);
    check_all_zero("reset");
    rst = 0;

    // init gating
    vid_req = 1; vid_addr = 24'h000123; cmd_ready = 1;
    repeat (500) cyc();
    chk("init_gate_hold", 32'(cmd_valid), 32'd0);
    init_done = 1;
    cyc(); cyc();
    chk("init_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("init_cmd_op", 32'(cmd_op), 32'd0);
    repeat (12) cyc();

    // simultaneous video + draw: read first
    vid_req = 1; drw_req = 1; vid_addr = 24'hABCDEF; drw_addr = 24'h13579B; drw_data = 32'hDEADBEEF;
    last_vack = 0; last_dack = 0;
    for (int i = 0; i < 80 && last_dack == 0; i++) cyc();
    chk("prio_vid_ack_seen", 32'(last_vack != 0), 32'd1);
    chk("prio_drw_ack_seen", 32'(last_dack != 0), 32'd1);
    chk("prio_order", 32'(last_vack < last_dack), 32'd1);

    // read return with fixed data, then a stray strobe while idle
    fixed_rd = 1; seen_vv = 0; vid_req = 1; vid_addr = 24'h00F00D;
    for (int i = 0; i < 60 && !seen_vv; i++) cyc();
    chk("rd_return_data", last_vdata, 32'h5555AAAA);
    fixed_rd = 0;
    for (int i = 0; i < 40 && m_rdout; i++) cyc();
    rd_valid = 1; rd_data = 32'h0BADF00D;
    cyc();
    chk("stray_rd_valid", 32'(vid_valid), 32'd0);

    // random traffic
    rq_mode = 1; rand_ready = 1; stray_en = 1; lat_min = 2; lat_max = 6;
    repeat (600) cyc();

    // constant video + draw pressure
    rq_mode = 2; rand_ready = 0; stray_en = 0; lat_min = 2; lat_max = 3;
    vid_req = 1; drw_req = 1; n_rd = 0; n_wr = 0; cur_run = 0; max_run = 0;
    repeat (300) cyc();
    chk("starve_write_seen", 32'(n_wr != 0), 32'(GUARD));
    chk("starve_max_run", 32'(max_run), GUARD ? 32'(SL) : 32'(n_rd));

    // drain, then stall the core to overflow refresh pending
    rq_mode = 0;
    repeat (40) cyc();
    vid_req = 0; drw_req = 0;
    repeat (20) cyc();
    vid_req = 1; hold_ready = 1;
    repeat (200) cyc();
    chk("overflow_set", 32'(refresh_overflow), 32'd1);
    hold_ready = 0;
    repeat (100) cyc();
    chk("overflow_sticky", 32'(refresh_overflow), 32'd1);

    // requester drops its request after the read was latched
    vid_req = 1; hold_ready = 1; cmd_ready = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      cyc();
      if (cmd_valid && cmd_op == 2'b00) got = 1;
      else cmd_ready = cmd_valid;
    end
    chk("drop_read_latched", 32'(got), 32'd1);
    vid_req = 0;
    repeat (3) cyc();
    hold_ready = 0; last_vack = 0;
    repeat (10) cyc();
    chk("drop_ack_still_sent", 32'(last_vack != 0), 32'd1);
    repeat (10) cyc();

    // asynchronous reset while a command is offered
    vid_req = 1; hold_ready = 1; cmd_ready = 0;
    for (int i = 0; i < 60 && !cmd_valid; i++) cyc();
    chk("pre_reset_issue", 32'(cmd_valid), 32'd1);
    #1 rst = 1;
    #1;
    check_all_zero("midreset");
    init_done = 0; cmd_done = 0; rd_valid = 0; cmd_ready = 0;
    model_reset();
    repeat (3) @(negedge clk133_p);
    rst = 0;
    repeat (10) cyc();
    chk("post_reset_wait", 32'(cmd_valid), 32'd0);
    hold_ready = 0; init_done = 1;
    cyc(); cyc();
    chk("restart_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("restart_cmd_op", 32'(cmd_op), 32'd0);
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
